dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_responder_dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants and FSM state type for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned MASK_W = XLEN / 8;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_responder_dmem_array.sv
// Word-wide storage with one synchronous port and per-byte write enables.
module dmem_array #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [XLEN/8-1:0] i_mask,
  input  logic [AW-1:0]     i_idx,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [XLEN-1:0]   o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_idx];
      if (i_we) begin
        for (int unsigned i = 0; i < XLEN / 8; i++) begin
          if (i_mask[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Handshake-based data-memory slave: one request at a time, fixed latency, byte-masked writes.
module dmem_responder #(
  parameter int unsigned      XLEN      = dmem_responder_pkg::XLEN,
  parameter int unsigned      DEPTH     = 256,
  parameter int unsigned      LAT       = 2,
  parameter logic [XLEN-1:0]  BASE_ADDR = XLEN'(dmem_responder_pkg::DEFAULT_BASE_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  import dmem_responder_pkg::*;

  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH) << 3;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_rd_ok;
  logic              r_we;
  logic              r_inr;
  logic [AW-1:0]     r_idx;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN/8-1:0] r_wmask;

  logic [XLEN-1:0]   w_off;
  logic              w_inr_in;
  logic              w_fire;
  logic              w_acc;
  logic              w_acc_we;
  logic              w_acc_inr;
  logic [AW-1:0]     w_acc_idx;
  logic [XLEN-1:0]   w_acc_wdata;
  logic [XLEN/8-1:0] w_acc_mask;
  logic              w_en;
  logic [XLEN-1:0]   w_rdata;

  assign w_off    = req_addr - BASE_ADDR;
  assign w_inr_in = (req_addr >= BASE_ADDR) && (w_off < SPAN);
  assign w_fire   = (r_state == IDLE) && req_valid && r_req_ready;

  // With LAT==1 the access happens on the accept edge, straight from the request fields.
  always_comb begin
    w_acc       = 1'b0;
    w_acc_we    = r_we;
    w_acc_inr   = r_inr;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    w_acc_mask  = r_wmask;
    if (LAT == 1) begin
      w_acc       = w_fire;
      w_acc_we    = req_we;
      w_acc_inr   = w_inr_in;
      w_acc_idx   = w_off[AW+2:3];
      w_acc_wdata = req_wdata;
      w_acc_mask  = req_wmask;
    end else begin
      w_acc = (r_state == WAIT) && (r_cnt == 4'd1);
    end
  end

  assign w_en = rst_n && w_acc && w_acc_inr;

  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_we    <= req_we;
      r_inr   <= w_inr_in;
      r_idx   <= w_off[AW+2:3];
      r_wdata <= req_wdata;
      r_wmask <= req_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_ok     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_fire) begin
            r_req_ready <= 1'b0;
            r_cnt       <= 4'(LAT - 1);
            r_state     <= (LAT > 1) ? WAIT : RESP;
          end
          if (w_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !w_acc_inr;
            r_rd_ok     <= w_acc_inr && !w_acc_we;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_acc) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !w_acc_inr;
            r_rd_ok     <= w_acc_inr && !w_acc_we;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (clk),
    .i_en    (w_en),
    .i_we    (w_acc_we),
    .i_mask  (w_acc_mask),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  // Array output is the last word read; it only becomes visible for in-range reads.
  assign rsp_rdata = r_rd_ok ? w_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LAT=2, DEPTH=256).
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .XLEN      (64),
    .DEPTH     (256),
    .LAT       (2),
    .BASE_ADDR (64'h0000_0000_8000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s timeout observed=none expected=handshake", tag);
  endtask

  // Full request/response; lat counts cycles from the accept cycle to the first rsp_valid cycle.
  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] mask, output logic [63:0] rdata, output logic err,
                     output int lat);
    int n;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout("req_ready");
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) timeout("rsp_valid");
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] held;
    logic        er;
    int          lat;
    int          n;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = 1'b0;

    tick(); tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err",   64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Full write then read
    txn(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, rd, er, lat);
    chk("wr_lat",   64'(lat), 64'd2);
    chk("wr_rdata", rd, 64'd0);
    chk("wr_err",   64'(er), 64'd0);
    txn(1'b0, 64'h8000_0010, '0, 8'h00, rd, er, lat);
    chk("rd_lat",   64'(lat), 64'd2);
    chk("rd_rdata", rd, 64'h1122_3344_5566_7788);
    chk("rd_err",   64'(er), 64'd0);

    // Single byte lane, low address bits ignored
    txn(1'b1, 64'h8000_0013, 64'h0000_00AB_0000_0000, 8'h10, rd, er, lat);
    txn(1'b0, 64'h8000_0010, '0, 8'h00, rd, er, lat);
    chk("mask_rdata", rd, 64'h1122_33AB_5566_7788);

    // Zero mask write leaves storage intact
    txn(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, lat);
    chk("zmask_err", 64'(er), 64'd0);
    txn(1'b0, 64'h8000_0010, '0, 8'h00, rd, er, lat);
    chk("zmask_rdata", rd, 64'h1122_33AB_5566_7788);

    // Backpressure: response held, competing request ignored
    req_we = 1'b0; req_addr = 64'h8000_0010; req_wmask = 8'h00; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("bp_accept");
    tick();
    req_we = 1'b1; req_addr = 64'h8000_0020; req_wdata = 64'hCAFE_F00D_0BAD_BEEF; req_wmask = 8'hFF;
    tick();
    chk("bp_valid_first", 64'(rsp_valid), 64'd1);
    held = rsp_rdata;
    chk("bp_rdata_first", held, 64'h1122_33AB_5566_7788);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rdata", rsp_rdata, held);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_after_valid", 64'(rsp_valid), 64'd0);
    chk("bp_after_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_held_accepted", 64'(req_ready), 64'd0);
    tick();
    chk("bp_held_rsp", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    txn(1'b0, 64'h8000_0020, '0, 8'h00, rd, er, lat);
    chk("bp_held_data", rd, 64'hCAFE_F00D_0BAD_BEEF);

    // Range boundaries
    txn(1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat);
    txn(1'b0, 64'h7FFF_FFF8, '0, 8'h00, rd, er, lat);
    chk("oor_lo_err",   64'(er), 64'd1);
    chk("oor_lo_rdata", rd, 64'd0);
    txn(1'b1, 64'h8000_0800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat);
    chk("oor_hi_err",   64'(er), 64'd1);
    chk("oor_hi_rdata", rd, 64'd0);
    txn(1'b0, 64'h8000_0000, '0, 8'h00, rd, er, lat);
    chk("word0_rdata", rd, 64'h0123_4567_89AB_CDEF);
    chk("word0_err",   64'(er), 64'd0);
    txn(1'b1, 64'h8000_07F8, 64'h7777_6666_5555_4444, 8'hFF, rd, er, lat);
    chk("last_wr_err", 64'(er), 64'd0);
    txn(1'b0, 64'h8000_07F8, '0, 8'h00, rd, er, lat);
    chk("last_rdata", rd, 64'h7777_6666_5555_4444);

    // Reset during WAIT drops the write
    txn(1'b1, 64'h8000_0028, 64'h5555_AAAA_5555_AAAA, 8'hFF, rd, er, lat);
    req_we = 1'b1; req_addr = 64'h8000_0028; req_wdata = 64'h0000_0000_DEAD_BEEF;
    req_wmask = 8'hFF; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("rst_mid_accept");
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("rst_mid_valid2", 64'(rsp_valid), 64'd0);
    chk("rst_mid_ready",  64'(req_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_mid_after_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_after_ready", 64'(req_ready), 64'd1);
    txn(1'b0, 64'h8000_0028, '0, 8'h00, rd, er, lat);
    chk("rst_mid_word5", rd, 64'h5555_AAAA_5555_AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
